icache_fill_ctrl: RTL



---
 rtl/icache_fill_ctrl_pkg.sv | 18 +
 rtl/icache_fill_ctrl_line_assembler.sv | 49 ++++
 rtl/icache_fill_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/icache_fill_ctrl_pkg.sv
// Shared icache constants and the refill FSM encoding.
// The optional fill performance counters are enabled by defining ICACHE_FILL_PERF_EN.
package icache_fill_ctrl_pkg;

    localparam int VIRT_ADDR_WIDTH         = 32;
    localparam int ICACHE_LINE_WIDTH       = 128;
    localparam int ICACHE_BYTEINLINE_WIDTH = $clog2(ICACHE_LINE_WIDTH / 8);
    localparam int ICACHE_BUS_WIDTH        = 32;
    localparam int ICACHE_FILL_NBEATS      = ICACHE_LINE_WIDTH / ICACHE_BUS_WIDTH;

    typedef enum logic [1:0] {
        FILL_IDLE    = 2'd0,
        FILL_REQ     = 2'd1,
        FILL_BEAT    = 2'd2,
        FILL_DELIVER = 2'd3
    } fill_state_t;

endpackage

// File: rtl/icache_fill_ctrl_line_assembler.sv
// Collects NBEATS bus beats into one cache line, lowest address beat in the low bits.
// i_clear restarts the beat counter; o_done flags the beat that completes the line.
module icache_fill_ctrl_line_assembler #(
    parameter int LINE_W = 128,
    parameter int BUS_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [BUS_W-1:0]  i_data,
    output logic [LINE_W-1:0] o_line,
    output logic              o_done
);

    localparam int NBEATS = LINE_W / BUS_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [BUS_W-1:0] r_words [NBEATS];

    assign o_done = i_load && (r_cnt == CNT_W'(NBEATS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= o_done ? '0 : r_cnt + 1'b1;
        end
    end

    // Each word slot only captures the beat whose index matches the counter.
    genvar gi;
    generate
        for (gi = 0; gi < NBEATS; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_words[gi] <= '0;
                end else if (i_load && (r_cnt == CNT_W'(gi))) begin
                    r_words[gi] <= i_data;
                end
            end
            assign o_line[gi*BUS_W +: BUS_W] = r_words[gi];
        end
    endgenerate

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction cache refill engine: one burst read per miss, line returned with a one-cycle strobe.
// Define ICACHE_FILL_PERF_EN to add the fill_count / fill_cycles counters.
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter int ADDR_W = VIRT_ADDR_WIDTH,
    parameter int LINE_W = ICACHE_LINE_WIDTH,
    parameter int BUS_W  = ICACHE_BUS_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_to_mem,
    input  logic [ADDR_W-1:0] req_to_mem_addr,
    output logic [LINE_W-1:0] in_data,
    output logic              in_data_ready,
    output logic              busy,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_gnt,
    input  logic              mem_rd_valid,
    input  logic [BUS_W-1:0]  mem_rd_data
`ifdef ICACHE_FILL_PERF_EN
    ,
    output logic [31:0]       fill_count,
    output logic [31:0]       fill_cycles
`endif
);

    localparam int OFF_W = $clog2(LINE_W / 8);

    fill_state_t       r_state;
    fill_state_t       w_state_next;
    logic [ADDR_W-1:0] r_line_addr;
    logic              w_busy;
    logic              w_mem_rd_req;
    logic              w_ready;
    logic              w_clear;
    logic              w_load;
    logic              w_last_beat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL_IDLE:    if (req_to_mem)  w_state_next = FILL_REQ;
            FILL_REQ:     if (mem_rd_gnt)  w_state_next = FILL_BEAT;
            FILL_BEAT:    if (w_last_beat) w_state_next = FILL_DELIVER;
            FILL_DELIVER: w_state_next = FILL_IDLE;
            default:      w_state_next = FILL_IDLE;
        endcase
    end

    // Grant, beats and requests are only acted upon in their own state.
    always_comb begin
        w_busy       = (r_state != FILL_IDLE);
        w_mem_rd_req = (r_state == FILL_REQ);
        w_ready      = (r_state == FILL_DELIVER);
        w_clear      = (r_state == FILL_REQ) && mem_rd_gnt;
        w_load       = (r_state == FILL_BEAT) && mem_rd_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_addr <= '0;
        end else if ((r_state == FILL_IDLE) && req_to_mem) begin
            r_line_addr <= {req_to_mem_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        end
    end

    icache_fill_ctrl_line_assembler #(
        .LINE_W (LINE_W),
        .BUS_W  (BUS_W)
    ) u_line_assembler (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_load  (w_load),
        .i_data  (mem_rd_data),
        .o_line  (in_data),
        .o_done  (w_last_beat)
    );

    assign busy          = w_busy;
    assign mem_rd_req    = w_mem_rd_req;
    assign mem_rd_addr   = r_line_addr;
    assign in_data_ready = w_ready;

`ifdef ICACHE_FILL_PERF_EN
    logic [31:0] r_fill_count;
    logic [31:0] r_fill_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill_count  <= '0;
            r_fill_cycles <= '0;
        end else begin
            if (w_ready) r_fill_count  <= r_fill_count + 32'd1;
            if (w_busy)  r_fill_cycles <= r_fill_cycles + 32'd1;
        end
    end

    assign fill_count  = r_fill_count;
    assign fill_cycles = r_fill_cycles;
`endif

endmodule
